// File: rtl/wash_phase_timer_if.sv
// Controller/timer handshake bundle for the wash phase timer.
// master = washing-machine controller, slave = wash_phase_timer.
interface wash_phase_timer_if #(
   parameter int CNT_W = 32
);
   logic             load;
   logic [CNT_W-1:0] load_value;
   logic             enable;
   logic             pause;
   logic             clear;
   logic             state_done;
   logic             done_pulse;
   logic             busy;
   logic             frozen;
   logic [CNT_W-1:0] remaining;

   modport master (
      output load, load_value, enable, pause, clear,
      input  state_done, done_pulse, busy, frozen, remaining
   );

   modport slave (
      input  load, load_value, enable, pause, clear,
      output state_done, done_pulse, busy, frozen, remaining
   );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase countdown timer paired with the washing-machine controller FSM.
// Optional macro WASH_TIMER_TICK_EN adds a TICK_DIV-clock prescaler so durations count in ticks.
module wash_phase_timer #(
   parameter int CNT_W    = 32,
   parameter int TICK_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   wash_phase_timer_if.slave   tmr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             state_done_q, state_done_d;
   logic             done_pulse_q, done_pulse_d;
   logic             busy_q, busy_d;
   logic             count_ok;
   logic             step;

   // Counting is only qualified by state and controller gating; clear/load take priority below.
   assign count_ok = (state_q == RUN) && tmr.enable && !tmr.pause;

`ifdef WASH_TIMER_TICK_EN
   localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PS_W-1:0] prescaler_q, prescaler_d;

   always_comb begin
      prescaler_d = prescaler_q;
      step        = 1'b0;
      if (tmr.clear || tmr.load) begin
         prescaler_d = '0;
      end else if (count_ok) begin
         if (prescaler_q == PS_W'(TICK_DIV - 1)) begin
            prescaler_d = '0;
            step        = 1'b1;
         end else begin
            prescaler_d = prescaler_q + PS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q <= '0;
      end else begin
         prescaler_q <= prescaler_d;
      end
   end
`else
   assign step = count_ok;
`endif

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      state_done_d = state_done_q;
      done_pulse_d = 1'b0;

      if (tmr.clear) begin
         state_d      = IDLE;
         remaining_d  = '0;
         state_done_d = 1'b0;
      end else if (tmr.load) begin
         remaining_d = tmr.load_value;
         if (tmr.load_value == '0) begin
            // A zero-length phase completes on the load edge itself.
            state_d      = DONE;
            state_done_d = 1'b1;
            done_pulse_d = 1'b1;
         end else begin
            state_d      = RUN;
            state_done_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               state_done_d = 1'b0;
            end
            RUN: begin
               if (step && (remaining_q != '0)) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_d      = DONE;
                     state_done_d = 1'b1;
                     done_pulse_d = 1'b1;
                  end
               end
            end
            DONE: begin
               remaining_d  = '0;
               state_done_d = 1'b1;
            end
            default: begin
               state_d      = IDLE;
               remaining_d  = '0;
               state_done_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         state_done_q <= 1'b0;
         done_pulse_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         state_done_q <= state_done_d;
         done_pulse_q <= done_pulse_d;
         busy_q       <= busy_d;
      end
   end

   assign tmr.state_done = state_done_q;
   assign tmr.done_pulse = done_pulse_q;
   assign tmr.busy       = busy_q;
   assign tmr.remaining  = remaining_q;
   assign tmr.frozen     = (state_q == RUN) && (tmr.pause || !tmr.enable);

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: directed table, corner sequences, random run vs. reference model.
module tb_wash_phase_timer;

   localparam int CNT_W = 32;
`ifdef WASH_TIMER_TICK_EN
   localparam int TDIV = 4;
`else
   localparam int TDIV = 1;
`endif

   logic clk;
   logic rst_n;

   wash_phase_timer_if #(.CNT_W(CNT_W)) bus ();

   wash_phase_timer #(.CNT_W(CNT_W), .TICK_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tmr   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference model: phase kind, remaining duration, and enabled clocks accumulated in the current tick.
   int          m_phase;
   int unsigned m_rem;
   bit          m_done;
   bit          m_pulse;
   int          m_acc;

   typedef struct {
      logic        ld;
      logic [31:0] lv;
      logic        en;
      logic        pa;
      logic        cl;
      logic        e_done;
      logic        e_pulse;
      logic        e_busy;
      logic [31:0] e_rem;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_rem   = 0;
      m_done  = 0;
      m_pulse = 0;
      m_acc   = 0;
   endtask

   task automatic model_edge(input bit ld, input int unsigned lv, input bit en, input bit pa, input bit cl);
      m_pulse = 0;
      if (cl) begin
         m_phase = 0; m_rem = 0; m_done = 0; m_acc = 0;
      end else if (ld) begin
         m_rem = lv;
         m_acc = 0;
         if (lv == 0) begin
            m_phase = 2; m_done = 1; m_pulse = 1;
         end else begin
            m_phase = 1; m_done = 0;
         end
      end else if (m_phase == 1 && en && !pa) begin
         m_acc++;
         if (m_acc == TDIV) begin
            m_acc = 0;
            m_rem--;
            if (m_rem == 0) begin
               m_phase = 2; m_done = 1; m_pulse = 1;
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit ld, input int unsigned lv, input bit en, input bit pa, input bit cl);
      @(negedge clk);
      bus.load       = ld;
      bus.load_value = lv;
      bus.enable     = en;
      bus.pause      = pa;
      bus.clear      = cl;
      @(posedge clk);
      model_edge(ld, lv, en, pa, cl);
      #1;
      checkOutput();
   endtask

   task automatic checkOutput();
      check("state_done", 32'(bus.state_done), 32'(m_done));
      check("done_pulse", 32'(bus.done_pulse), 32'(m_pulse));
      check("busy",       32'(bus.busy),       32'(m_phase == 1));
      check("frozen",     32'(bus.frozen),     32'((m_phase == 1) && (bus.pause || !bus.enable)));
      check("remaining",  bus.remaining,       m_rem);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.load = 0; bus.load_value = '0; bus.enable = 0; bus.pause = 0; bus.clear = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Counts enabled cycles until state_done, starting from an offset of cycles already spent.
   task automatic wait_done(input string name, input int already, input int exp);
      int c;
      bit seen;
      c = already;
      seen = 0;
      for (int i = 0; i < 200 * TDIV && !seen; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         c++;
         if (bus.state_done) seen = 1;
      end
      if (!seen) c = -1;
      check(name, c, exp);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.load = 0; bus.load_value = '0; bus.enable = 0; bus.pause = 0; bus.clear = 0;
      model_reset();
      do_reset();

`ifndef WASH_TIMER_TICK_EN
      vecs[0]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5};
      vecs[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 4};
      vecs[2]  = '{0, 0, 1, 0, 0, 0, 0, 1, 3};
      vecs[3]  = '{0, 0, 1, 0, 0, 0, 0, 1, 2};
      vecs[4]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
      vecs[5]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0};
      vecs[6]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
      vecs[7]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
      vecs[8]  = '{1, 0, 1, 0, 0, 1, 1, 0, 0};
      vecs[9]  = '{1, 3, 1, 0, 0, 0, 0, 1, 3};
      vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 2};
      vecs[11] = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
      vecs[12] = '{0, 0, 1, 0, 0, 1, 1, 0, 0};
      vecs[13] = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
      vecs[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].pa, vecs[i].cl);
         check($sformatf("vec%0d_done", i),  32'(bus.state_done), 32'(vecs[i].e_done));
         check($sformatf("vec%0d_pulse", i), 32'(bus.done_pulse), 32'(vecs[i].e_pulse));
         check($sformatf("vec%0d_busy", i),  32'(bus.busy),       32'(vecs[i].e_busy));
         check($sformatf("vec%0d_rem", i),   bus.remaining,       vecs[i].e_rem);
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         check("held_done", 32'(bus.state_done), 32'd0);
      end
`endif

      // Load 5 continuously enabled: done exactly 5 ticks after the load edge, then held.
      applyStimulus(1, 5, 1, 0, 0);
      wait_done("latency_5", 0, 5 * TDIV);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 1, 0, 0);
         check("done_held", 32'(bus.state_done), 32'd1);
      end

      // Pause for three cycles after two steps.
      applyStimulus(1, 6, 1, 0, 0);
      repeat (2 * TDIV) applyStimulus(0, 0, 1, 0, 0);
      check("rem_before_pause", bus.remaining, 32'd4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 1, 0);
         check("pause_frozen", 32'(bus.frozen), 32'd1);
         check("pause_rem", bus.remaining, 32'd4);
      end
      wait_done("latency_paused", 2 * TDIV + 3, 6 * TDIV + 3);

      // Load 0 then reload 3.
      applyStimulus(1, 0, 1, 0, 0);
      check("zero_done", 32'(bus.state_done), 32'd1);
      check("zero_pulse", 32'(bus.done_pulse), 32'd1);
      applyStimulus(1, 3, 1, 0, 0);
      check("reload_drops_done", 32'(bus.state_done), 32'd0);
      wait_done("latency_3", 0, 3 * TDIV);

      // Reload on the edge the final step would have occurred.
      applyStimulus(1, 4, 1, 0, 0);
      repeat (4 * TDIV - 1) applyStimulus(0, 0, 1, 0, 0);
      check("rem_at_one", bus.remaining, 32'd1);
      applyStimulus(1, 7, 1, 0, 0);
      check("collide_pulse", 32'(bus.done_pulse), 32'd0);
      check("collide_done", 32'(bus.state_done), 32'd0);
      check("collide_rem", bus.remaining, 32'd7);
      wait_done("latency_7", 0, 7 * TDIV);

      // Clear beats simultaneous load.
      applyStimulus(1, 10, 1, 0, 0);
      repeat (4 * TDIV) applyStimulus(0, 0, 1, 0, 0);
      check("rem_six", bus.remaining, 32'd6);
      applyStimulus(1, 9, 1, 0, 1);
      check("clear_rem", bus.remaining, 32'd0);
      check("clear_busy", 32'(bus.busy), 32'd0);
      check("clear_done", 32'(bus.state_done), 32'd0);

      // Mid-tick pause: load 3, one enabled cycle, two paused cycles.
      applyStimulus(1, 3, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      wait_done("latency_midtick", 3, 3 * TDIV + 2);

      // Asynchronous reset in the middle of a phase.
      applyStimulus(1, 8, 1, 0, 0);
      repeat (3) applyStimulus(0, 0, 1, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rem", bus.remaining, 32'd0);
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_done", 32'(bus.state_done), 32'd0);
      check("async_pulse", 32'(bus.done_pulse), 32'd0);
      check("async_frozen", 32'(bus.frozen), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised run against the reference model.
      for (int i = 0; i < 600; i++) begin
         bit ld, en, pa, cl;
         int unsigned lv;
         ld = ($urandom_range(0, 9) == 0);
         lv = $urandom_range(0, 7);
         en = ($urandom_range(0, 3) != 0);
         pa = ($urandom_range(0, 4) == 0);
         cl = ($urandom_range(0, 29) == 0);
         applyStimulus(ld, lv, en, pa, cl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
Phase countdown timer that sits opposite the washing-machine controller FSM. It accepts that controller's phase duration, load strobe, enable and pause, and returns state_done when the loaded duration has fully elapsed. It is the timing half of the controller/timer handshake: one instance per machine, in the same clock domain as the controller.

Parameters:
CNT_W, 32, width of load value and down-counter.
TICK_DIV, 1000, clocks per tick when WASH_TIMER_TICK_EN is defined (must be >= 2); unused otherwise.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
load  input  1  connects to controller next_state_flag; when high, latch load_value this cycle.
load_value  input  CNT_W  connects to controller state_time; duration in clocks (or ticks with the macro).
enable  input  1  connects to controller timer_enable; counting permitted when high.
pause  input  1  connects to controller timer_pause; freezes counting when high.
clear  input  1  synchronous abort; return to IDLE.
state_done  output  1  level: duration elapsed; held until next load or clear.
done_pulse  output  1  one-cycle strobe on entry to DONE.
busy  output  1  high in RUN.
frozen  output  1  high in RUN while (pause or !enable).
remaining  output  CNT_W  current count value.

Behaviour:
- Reset (async, rst_n low): state IDLE, remaining=0, state_done=0, done_pulse=0, busy=0, frozen=0, prescaler=0. Reset mid-count abandons the phase; no done is produced.
- States: IDLE, RUN, DONE. All outputs are registered except frozen.
- Priority per clock edge: clear > load > count.
  - clear: go to IDLE, remaining=0, state_done=0. Any simultaneous load is ignored.
- load (not clear):
  - remaining<=load_value; state_done<=0.
  - load_value!=0 -> RUN. load_value==0 -> DONE on the same edge, so state_done=1 and done_pulse=1 the next cycle.
  - Loading in any state restarts the phase, including mid-RUN.
  - While load is held high across cycles, the block reloads every cycle; the controller's idle state does this with value 0.
- Count step: occurs in RUN when enable && !pause && !load && !clear, and (with the macro) the prescaler wraps.
  - Each step: remaining<=remaining-1.
  - The step from 1 to 0 enters DONE: state_done=1, done_pulse=1 for exactly one cycle.
- Latency: load of N (no macro, continuously enabled) at edge E -> state_done high after edge E+N. Each cycle of pause or !enable adds one cycle.
- DONE: remaining=0, state_done held, enable and pause ignored. Leaves only on load or clear.
- IDLE: enable and pause ignored; state_done=0.
- A load and a final step on the same edge: the load wins and no done_pulse is produced.
- No wrap-around: remaining never decrements below 0.
- frozen = (state==RUN) && (pause || !enable).

Optional Feature:
WASH_TIMER_TICK_EN:
- Defined: add a prescaler 0..TICK_DIV-1. It advances only when the count-step conditions other than the wrap hold, it is cleared on load, clear and reset, and a count step occurs only on the cycle it wraps. load_value is then in ticks, and latency for load N is N*TICK_DIV enabled cycles. The prescaler holds its value during pause.
- Undefined: no prescaler; a step occurs on every qualifying cycle.

Test Plan:
1. Reset, load_value=5 with load one cycle, enable=1, pause=0 -> remaining 5,4,3,2,1,0; state_done rises 5 cycles after load edge; done_pulse high 1 cycle; state_done stays 1 for 10 further cycles.
2. Load 6, pause=1 for 3 cycles after 2 steps -> remaining holds at 4 with frozen=1 for those cycles; state_done at load+9.
3. Load 0 -> state_done=1 and done_pulse=1 next cycle. Then load 3 -> state_done drops at that edge and re-asserts 3 cycles later.
4. Load 4, then at remaining=1 assert load=1 with value 7 on the same edge the final step would occur -> no done_pulse; remaining=7; done 7 cycles later.
5. Load 10, then clear and load together at remaining=6 -> IDLE, remaining=0, state_done=0. Separately, pull rst_n low mid-RUN -> all outputs 0 immediately (async).
6. With WASH_TIMER_TICK_EN, TICK_DIV=4, load 3 -> state_done after 12 enabled cycles. A 2-cycle pause mid-tick -> done at 14.
